// File: rtl/wb_stage.sv
// Writeback stage: merges ALU results and buffered load returns onto one register-file write port.
// Optional build macro WB_BYPASS_EN lets a load reach an idle, empty stage without entering the queue.
module wb_stage #(
  parameter int unsigned LQ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_rd,
  input  logic [31:0]                alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_rd,
  input  logic [31:0]                mem_data,
  output logic                       wen,
  output logic [4:0]                 regWAddr,
  output logic [31:0]                regWData,
  output logic [$clog2(LQ_DEPTH):0]  lq_count,
  output logic                       busy
);

  localparam int unsigned PtrW = $clog2(LQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [4:0]      lqRd   [LQ_DEPTH];
  logic [31:0]     lqData [LQ_DEPTH];
  logic [PtrW-1:0] headPtr;
  logic [PtrW-1:0] tailPtr;

  logic            lqFull;
  logic            lqEmpty;
  logic            pop;
  logic            push;
  logic            bypass;
  logic            selValid;
  logic [4:0]      selRd;
  logic [31:0]     selData;

  assign lqFull    = (lq_count == CntW'(LQ_DEPTH));
  assign lqEmpty   = (lq_count == '0);
  assign alu_ready = !lqFull;
  assign busy      = !lqEmpty || wen;

  // Source select: full queue beats ALU, ALU beats a non-full queue, bypass is last resort.
  always_comb begin
    pop      = 1'b0;
    bypass   = 1'b0;
    selValid = 1'b0;
    selRd    = lqRd[headPtr];
    selData  = lqData[headPtr];
    if (lqFull) begin
      pop      = 1'b1;
      selValid = 1'b1;
    end else if (alu_valid) begin
      selValid = 1'b1;
      selRd    = alu_rd;
      selData  = alu_data;
    end else if (!lqEmpty) begin
      pop      = 1'b1;
      selValid = 1'b1;
`ifdef WB_BYPASS_EN
    end else if (mem_valid) begin
      bypass   = 1'b1;
      selValid = 1'b1;
      selRd    = mem_rd;
      selData  = mem_data;
`endif
    end
    push = mem_valid && !bypass;
  end

  // Queue storage carries no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      lqRd[tailPtr]   <= mem_rd;
      lqData[tailPtr] <= mem_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      lq_count <= '0;
    end else begin
      if (pop)  headPtr <= headPtr + PtrW'(1);
      if (push) tailPtr <= tailPtr + PtrW'(1);
      lq_count <= lq_count + CntW'(push) - CntW'(pop);
    end
  end

  // Write port register; rd = 0 entries update address/data but never write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wen      <= 1'b0;
      regWAddr <= '0;
      regWData <= '0;
    end else if (selValid) begin
      wen      <= (selRd != 5'd0);
      regWAddr <= selRd;
      regWData <= selData;
    end else begin
      wen      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus random traffic against a queue-based model.
module tb_wb_stage;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wen;
  logic [4:0]  regWAddr;
  logic [31:0] regWData;
  logic [2:0]  lq_count;
  logic        busy;

  wb_stage #(.LQ_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .wen(wen), .regWAddr(regWAddr), .regWData(regWData),
    .lq_count(lq_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nAsserts = 0;
  int nFail = 0;

  ent_t        q[$];
  logic        expWen = 1'b0;
  logic [4:0]  expAddr = '0;
  logic [31:0] expData = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".wen"}, 32'(wen), 32'(expWen));
    check({tag, ".regWAddr"}, 32'(regWAddr), 32'(expAddr));
    check({tag, ".regWData"}, regWData, expData);
    check({tag, ".lq_count"}, 32'(lq_count), 32'(q.size()));
    check({tag, ".busy"}, 32'(busy), 32'((q.size() != 0) || expWen));
  endtask

  // One clock of traffic: apply inputs, predict from the queue model, advance, compare.
  task automatic step(input string tag, input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    ent_t e;
    logic sel;
    logic byp;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    check({tag, ".alu_ready"}, 32'(alu_ready), 32'(q.size() != DEPTH));
    sel = 1'b0;
    byp = 1'b0;
    e   = '0;
    if (q.size() == DEPTH) begin
      e = q.pop_front(); sel = 1'b1;
    end else if (av) begin
      e = '{rd: ard, data: ad}; sel = 1'b1;
    end else if (q.size() != 0) begin
      e = q.pop_front(); sel = 1'b1;
`ifdef WB_BYPASS_EN
    end else if (mv) begin
      e = '{rd: mrd, data: md}; sel = 1'b1; byp = 1'b1;
`endif
    end
    if (mv && !byp) q.push_back('{rd: mrd, data: md});
    if (sel) begin
      expWen = (e.rd != 5'd0); expAddr = e.rd; expData = e.data;
    end else begin
      expWen = 1'b0;
    end
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    check("reset.alu_ready", 32'(alu_ready), 32'd1);
    reset = 1'b1;
    idle("idle");
    check("idle.busy", 32'(busy), 32'd0);

    // ALU result written one cycle after acceptance
    step("alu", 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    check("alu.wen_now", 32'(wen), 32'd1);
    check("alu.addr_now", 32'(regWAddr), 32'd5);
    check("alu.data_now", regWData, 32'h1234);
    idle("alu_after");
    check("alu_after.wen", 32'(wen), 32'd0);

    // Single load on an idle stage
    step("load", 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFEBABE);
`ifdef WB_BYPASS_EN
    check("load.bypass_wen", 32'(wen), 32'd1);
    check("load.bypass_count", 32'(lq_count), 32'd0);
`else
    check("load.queued_wen", 32'(wen), 32'd0);
    check("load.queued_count", 32'(lq_count), 32'd1);
`endif
    idle("load2");
`ifndef WB_BYPASS_EN
    check("load2.wen", 32'(wen), 32'd1);
    check("load2.addr", 32'(regWAddr), 32'd7);
`endif
    idle("load3");

    // ALU starves loads until the queue fills
    for (int i = 1; i <= 4; i++)
      step("starve", 1'b1, 5'(20 + i), 32'(i * 16), 1'b1, 5'(i), 32'hA000_0000 + 32'(i));
    check("starve.count", 32'(lq_count), 32'd4);
    check("starve.alu_ready", 32'(alu_ready), 32'd0);
    step("full_pop", 1'b1, 5'd30, 32'h30, 1'b0, 5'd0, 32'd0);
    check("full_pop.addr", 32'(regWAddr), 32'd1);
    check("full_pop.alu_ready", 32'(alu_ready), 32'd1);
    repeat (4) idle("drain");
    check("drain.count", 32'(lq_count), 32'd0);

    // Simultaneous push and pop at full
    for (int i = 1; i <= 4; i++)
      step("refill", 1'b1, 5'(10 + i), 32'(i), 1'b1, 5'(i), 32'hB000_0000 + 32'(i));
    step("pushpop", 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999);
    check("pushpop.count", 32'(lq_count), 32'd4);
    check("pushpop.addr", 32'(regWAddr), 32'd1);
    repeat (4) idle("drain9");
    check("drain9.last_addr", 32'(regWAddr), 32'd9);
    idle("drain9_idle");

    // rd = 0 consumes without writing
    step("rd0", 1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'd0);
    check("rd0.wen", 32'(wen), 32'd0);
    check("rd0.data", regWData, 32'hFFFF);

    // Asynchronous reset with three loads queued
    for (int i = 1; i <= 3; i++)
      step("prefill", 1'b1, 5'(i), 32'(i), 1'b1, 5'(i + 3), 32'(i + 100));
    check("prefill.count", 32'(lq_count), 32'd3);
    reset = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0;
    #1;
    q.delete();
    expWen = 1'b0; expAddr = '0; expData = '0;
    checkAll("async_rst");
    check("async_rst.alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkAll("post_rst");

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic av, mv;
      av = ($urandom_range(0, 9) < 5);
      mv = ($urandom_range(0, 9) < 5);
      step("rand", av, 5'($urandom_range(0, 31)), $urandom(), mv, 5'($urandom_range(0, 31)), $urandom());
    end
    repeat (6) idle("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage that sits directly upstream of the general register file and drives its single write port. It merges two result sources: a single-cycle ALU result path with backpressure, and a load-return path from the memory unit that cannot be stalled and is therefore buffered in a small load queue. Every cycle it retires at most one result as a registered `wen`/`regWAddr`/`regWData` triple.

## Interface
- `LQ_DEPTH`, default 4: load queue entries; power of two, at least 2.
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low (0 = reset).
- `alu_valid` input 1: ALU result is presented this cycle.
- `alu_rd` input 5: ALU destination register.
- `alu_data` input 32: ALU result.
- `alu_ready` output 1: the stage accepts the ALU result this cycle.
- `mem_valid` input 1: load data is returned this cycle. There is no ready; the data is always accepted.
- `mem_rd` input 5: load destination register.
- `mem_data` input 32: load data, already aligned and extended.
- `wen` output 1: register file write enable (registered).
- `regWAddr` output 5: register file write address (registered).
- `regWData` output 32: register file write data (registered).
- `lq_count` output log2(LQ_DEPTH)+1: current load queue occupancy.
- `busy` output 1: high when `lq_count != 0` or `wen` is high.

## Operation
- The load queue is a FIFO of {rd, data} with a head pointer, a tail pointer and a count. Pointers wrap modulo `LQ_DEPTH`.
- `alu_ready` is `(lq_count != LQ_DEPTH)` and is decoded combinationally from registered state only. It never depends on `alu_valid`.
- The stage selects one source per cycle, in this priority order:
  1. Queue full: pop the head; the ALU is stalled.
  2. `alu_valid`: take the ALU result. This is the ALU handshake.
  3. Queue not empty: pop the head.
  4. `WB_BYPASS_EN` is defined, the queue is empty and `mem_valid` is high: bypass the load straight to the output. The load is not pushed.
  5. Otherwise nothing is selected.
- Push happens when `mem_valid` is high and the load was not bypassed. A push and a pop in the same cycle leave the count unchanged. When the queue is full a pop is guaranteed, so the queue cannot overflow.
- Output register on each edge:
  - `wen <= selected && rd != 0`.
  - `regWAddr` and `regWData` load the selected entry's fields whenever something is selected, including rd = 0.
  - Otherwise `regWAddr` and `regWData` hold their values.
- A selected entry with rd = 0 is consumed with no write.
- ALU results can starve loads while the queue is not full. Loads are guaranteed service once the queue reaches `LQ_DEPTH`. Load order is preserved; no ordering is guaranteed between ALU results and loads.

## Timing
- Reset (`reset` = 0, asynchronous):
  - Outputs: `wen` = 0, `regWAddr` = 0, `regWData` = 0, `lq_count` = 0, `busy` = 0.
  - Internal state: pointers = 0.
  - `alu_ready` = 1 as soon as reset asserts.
  - An assertion mid-operation discards queued loads and any pending write. No write is issued in the cycle after release unless a source is accepted at the first edge after release.
- ALU latency: accepted at edge N gives `wen` high from edge N through edge N+1, i.e. one cycle.
- Load latency, queued: pushed at edge N, popped at edge N+1 at the earliest, `wen` high after edge N+1. That is 2 cycles.
- Load latency, bypassed: 1 cycle. It applies only with `WB_BYPASS_EN`, an empty queue and no `alu_valid`.
- Throughput: one register file write per cycle.
- Full boundary: with `lq_count == LQ_DEPTH` and `mem_valid` high, the pop and the push occur on the same edge and the count stays at `LQ_DEPTH`.

## Configuration
- `WB_BYPASS_EN` defined: priority step 4 is active. A load arriving at an empty queue with no competing ALU result is written after 1 cycle and never enters the queue.
- `WB_BYPASS_EN` undefined: every load is pushed into the queue, and load latency is at least 2 cycles.
- All other behaviour is identical in both builds.

## Test plan
- Reset then idle: `reset` = 0 for 2 cycles, then released with no valids → `wen` = 0, `lq_count` = 0, `busy` = 0, `alu_ready` = 1.
- ALU only: `alu_valid`=1, rd=5, data=0x1234 for 1 cycle → next cycle `wen` = 1, `regWAddr` = 5, `regWData` = 0x1234. Then `wen` = 0.
- Load latency: single `mem_valid` with rd=7, data=0xCAFEBABE, queue empty, no ALU:
  - with `WB_BYPASS_EN` → `wen` 1 cycle later.
  - without it → `wen` 2 cycles later and `lq_count` = 1 in between.
- Starvation then full: `alu_valid` held at 1 while 4 loads arrive on consecutive cycles (rd 1–4) → `lq_count` reaches 4 and `alu_ready` drops to 0. Loads rd 1–4 are then written in order. `alu_ready` returns to 1 when the count drops below 4.
- Simultaneous push and pop at full: queue full and `mem_valid` (rd=9) high → the head is written, `lq_count` stays 4, and rd 9 is written last in order.
- rd = 0 and mid-operation reset:
  - ALU result with rd=0, data=0xFFFF → `wen` stays 0 while `regWAddr`/`regWData` update.
  - `reset` asserted with `lq_count` = 3 → count = 0 immediately and no stale write after release.
